pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Fetch-stage controller of the multi-cycle CPU. Holds the architectural PC, handles the instruction-memory handshake, and captures the fetched word into the instruction register. When a fetch completes it applies PC+4 or any pending branch/jump redirect. It feeds the downstream PC-old register by driving that register's data input and its one-cycle write-enable pulse with the address of the instruction just fetched.

## Interface
Parameters:
- XLEN, 32: datapath width.
- RESET_PC, 32'h0000_0000: PC value after reset.

Ports:
- CLK  in  1  the single clock; all state updates on posedge CLK.
- RSTn  in  1  asynchronous, active-low reset.
- fetch_start  in  1  control unit requests one instruction fetch.
- PCWr  in  1  unconditional PC write (jump).
- PCWrCond  in  1  conditional PC write (branch).
- F3_result  in  1  branch condition result; qualifies PCWrCond.
- pc_target  in  XLEN  redirect target address.
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  XLEN  request address; equals PC_Q.
- imem_ready  in  1  memory accepts the request and returns data this cycle.
- imem_rdata  in  32  instruction word; valid when imem_req && imem_ready.
- PC_Q  out  XLEN  current PC.
- IR_Q  out  32  instruction register.
- PC_old_D  out  XLEN  address of the last fetched instruction, to the PC-old register.
- PColdWr  out  1  one-cycle write-enable to the PC-old register.
- fetch_done  out  1  one-cycle pulse when IR_Q holds a new instruction.
- align_err  out  1  one-cycle pulse when a redirect target has nonzero bits [1:0].

## Operation
- Redirect request: PC_W = PCWr | (PCWrCond & F3_result), evaluated every cycle.
- Redirect targets are always loaded as {pc_target[XLEN-1:2], 2'b00}.
- align_err pulses in the cycle after any PC_W with pc_target[1:0] != 0.
- State machine:
  - IDLE: fetch_start → REQ. PC_W loads the PC at the edge. If PC_W and fetch_start are both asserted, the request goes out with the new PC.
  - REQ: imem_req=1 and imem_addr=PC_Q, held stable until imem_ready.
    - At the acceptance edge: IR_Q ← imem_rdata; PC_old_D ← PC_Q; PC_Q ← the pending target if one exists, otherwise PC_Q+4; pending flag cleared; → DONE.
    - PC_W during REQ does not change PC_Q. It latches the pending target; the last one wins. PC_W in the acceptance cycle itself also counts as pending and is applied at that edge.
  - DONE: PColdWr=1 and fetch_done=1 for exactly this cycle. fetch_start → REQ (back-to-back fetch); otherwise → IDLE. PC_W loads the PC at the edge, as in IDLE.
- Arithmetic: PC+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- fetch_start asserted in REQ is ignored.

## Timing
- Reset (asynchronous, immediate):
  - PC_Q=RESET_PC; IR_Q=0; PC_old_D=0.
  - imem_req=0, PColdWr=0, fetch_done=0, align_err=0.
  - Pending flag cleared; state IDLE.
  - Asserting reset during REQ drops the request in the same cycle. No IR or PC update occurs.
- Minimum latency with imem_ready already high:
  - fetch_start at cycle 0;
  - REQ in cycle 1, accepted at the end of cycle 1;
  - DONE in cycle 2 (IR_Q, PC_old_D, PColdWr, fetch_done all valid);
  - IDLE in cycle 3.
- Each wait cycle of imem_ready adds one cycle of latency.
- All outputs are registered or decoded directly from state. imem_addr comes straight from PC_Q.
- PColdWr is never high for two consecutive cycles. Back-to-back fetches give a DONE–REQ–DONE pattern.

## Structure
- Shared package cpu_pkg holds:
  - fetch state enum {IDLE, REQ, DONE};
  - INSTR_BYTES=4;
  - the RESET_PC default.
- One sub-module, pc_redirect_latch, holds the pending-flag and target register with align masking and align_err generation. Everything else lives in pc_fetch_unit.

## Test plan
- Reset, then fetch_start at 0 with imem_ready=1 and rdata=32'h0010_0093: in DONE, IR_Q=32'h0010_0093, PC_old_D=0, PColdWr=1 for one cycle, PC_Q=4.
- imem_ready held low for 3 cycles: imem_req and imem_addr stay stable; DONE arrives 3 cycles later than the minimum; exactly one PColdWr pulse.
- PCWrCond=1 with F3_result=0 in IDLE: PC unchanged. With F3_result=1 and pc_target=32'h40: PC_Q=32'h40 on the next edge, and the next fetch uses address 32'h40.
- PCWr with target 32'h80 during REQ at PC=32'h10: imem_addr stays 32'h10; after acceptance PC_Q=32'h80 and PC_old_D=32'h10.
- Two effects checked separately:
  - PC_Q=32'hFFFF_FFFC, fetch completes: PC_Q=0.
  - PCWr with target 32'h43: PC_Q=32'h40 and align_err pulses once.
- RSTn asserted mid-REQ: imem_req drops immediately; PC_Q=RESET_PC and IR_Q=0; no PColdWr pulse after reset is released.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU fetch stage.
//   fetch_state_e     : fetch controller states (idle / request out / done)
//   INSTR_BYTES       : byte stride between sequential instructions
//   RESET_PC_DEFAULT  : default architectural PC after reset
//   word_align32()    : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  localparam int unsigned  INSTR_BYTES      = 32'd4;
  localparam logic [31:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  // Instructions are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] word_align32(input logic [31:0] addr);
    word_align32 = {addr[31:2], 2'b00};
  endfunction

endpackage : cpu_pkg

// File: rtl/pc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-memory request/response handshake between the fetch unit and
// the instruction memory.
//   imem_req   : request valid (fetch unit -> memory)
//   imem_addr  : request address (fetch unit -> memory)
//   imem_ready : request accepted, data returned this cycle (memory -> fetch)
//   imem_rdata : instruction word, valid with imem_req && imem_ready
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface : pc_fetch_unit_if

// File: rtl/pc_redirect_latch.sv
// -----------------------------------------------------------------------------
// pc_redirect_latch
// Holds a branch/jump redirect that arrives while a fetch is outstanding, so
// it can be applied when the fetch completes. Also word-aligns redirect
// targets and flags misaligned ones.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   pc_w_i             : redirect request this cycle
//   capture_en_i       : fetch outstanding and not completing; redirect is held
//   clear_i            : fetch completing this cycle; pending redirect consumed
//   target_i           : raw redirect target
//   target_aligned_o   : target_i with bits [1:0] forced to zero (combinational)
//   pending_o          : a held redirect exists
//   pend_target_o      : the held (aligned) redirect target
//   align_err_o        : one-cycle pulse after a redirect with misaligned target
// -----------------------------------------------------------------------------
module pc_redirect_latch
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pc_w_i,
  input  logic            capture_en_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] target_aligned_o,
  output logic            pending_o,
  output logic [XLEN-1:0] pend_target_o,
  output logic            align_err_o
);

  logic            pending_q;
  logic [XLEN-1:0] pend_target_q;
  logic            align_err_q;
  logic            misaligned_s;

  assign target_aligned_o = {target_i[XLEN-1:2], 2'b00};
  assign misaligned_s     = |target_i[1:0];

  // Pending redirect capture: the latest redirect during a wait wins; the
  // completing fetch consumes it (a same-cycle redirect is applied directly
  // by the fetch unit, so nothing needs to be held then).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q     <= 1'b0;
      pend_target_q <= '0;
    end else if (clear_i) begin
      pending_q     <= 1'b0;
      pend_target_q <= pend_target_q;
    end else if (capture_en_i && pc_w_i) begin
      pending_q     <= 1'b1;
      pend_target_q <= target_aligned_o;
    end else begin
      pending_q     <= pending_q;
      pend_target_q <= pend_target_q;
    end
  end

  // Misalignment flag: reported for every redirect regardless of fetch state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= pc_w_i & misaligned_s;
    end
  end

  assign pending_o     = pending_q;
  assign pend_target_o = pend_target_q;
  assign align_err_o   = align_err_q;

endmodule : pc_redirect_latch

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Fetch-stage controller: holds the architectural PC, runs the instruction
// memory handshake, captures the fetched word into IR, and advances the PC
// (PC+4 or redirect) when a fetch completes. Drives the PC-old register with
// the address of the instruction just fetched plus a one-cycle write enable.
// Ports:
//   CLK, RSTn     : clock, asynchronous active-low reset
//   fetch_start   : request one instruction fetch
//   PCWr          : unconditional PC write (jump)
//   PCWrCond      : conditional PC write (branch), qualified by F3_result
//   F3_result     : branch condition result
//   pc_target     : redirect target
//   imem          : instruction-memory handshake (master side)
//   PC_Q          : current PC
//   IR_Q          : instruction register
//   PC_old_D      : address of the last fetched instruction
//   PColdWr       : one-cycle write enable to the PC-old register
//   fetch_done    : one-cycle pulse, IR_Q holds a new instruction
//   align_err     : one-cycle pulse after a redirect with misaligned target
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              fetch_start,
  input  logic              PCWr,
  input  logic              PCWrCond,
  input  logic              F3_result,
  input  logic [XLEN-1:0]   pc_target,
  pc_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]   PC_Q,
  output logic [31:0]       IR_Q,
  output logic [XLEN-1:0]   PC_old_D,
  output logic              PColdWr,
  output logic              fetch_done,
  output logic              align_err
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_old_q;
  logic [31:0]     ir_q;

  logic            pc_w_s;
  logic            in_req_s;
  logic            accept_s;
  logic            capture_s;
  logic [XLEN-1:0] pc_inc_s;
  logic [XLEN-1:0] tgt_aligned_s;
  logic            pending_s;
  logic [XLEN-1:0] pend_target_s;

  assign pc_w_s    = PCWr | (PCWrCond & F3_result);
  assign in_req_s  = (state_q == ST_REQ);
  assign accept_s  = in_req_s & imem.imem_ready;
  assign capture_s = in_req_s & ~imem.imem_ready;
  // Wraps modulo 2^XLEN by construction.
  assign pc_inc_s  = pc_q + XLEN'(INSTR_BYTES);

  pc_redirect_latch #(
    .XLEN (XLEN)
  ) u_redirect (
    .clk_i            (CLK),
    .rst_ni           (RSTn),
    .pc_w_i           (pc_w_s),
    .capture_en_i     (capture_s),
    .clear_i          (accept_s),
    .target_i         (pc_target),
    .target_aligned_o (tgt_aligned_s),
    .pending_o        (pending_s),
    .pend_target_o    (pend_target_s),
    .align_err_o      (align_err)
  );

  // Next-PC selection: outside a fetch a redirect loads directly; during a
  // fetch the PC is frozen (it is the request address) and only moves at
  // acceptance, where a same-cycle redirect beats a held one, which beats +4.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (pc_w_s) begin
          pc_d = tgt_aligned_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_REQ: begin
        if (accept_s) begin
          if (pc_w_s) begin
            pc_d = tgt_aligned_s;
          end else if (pending_s) begin
            pc_d = pend_target_s;
          end else begin
            pc_d = pc_inc_s;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Fetch FSM with PC, IR and PC-old registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0000_0000;
      pc_old_q <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= fetch_start ? ST_REQ : ST_IDLE;
        end
        ST_REQ: begin
          if (imem.imem_ready) begin
            ir_q     <= imem.imem_rdata;
            pc_old_q <= pc_q;
            state_q  <= ST_DONE;
          end else begin
            state_q  <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req  = in_req_s;
  assign imem.imem_addr = pc_q;
  assign PC_Q           = pc_q;
  assign IR_Q           = ir_q;
  assign PC_old_D       = pc_old_q;
  assign PColdWr        = (state_q == ST_DONE);
  assign fetch_done     = (state_q == ST_DONE);

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed and randomized stimulus for pc_fetch_unit. A transaction-level
// model predicts each completed fetch (instruction word, fetch address, next
// PC) and the per-cycle visible behaviour; a monitor compares the DUT.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc_old;
  } exp_t;

  logic        clk;
  logic        RSTn;
  logic        fetch_start;
  logic        PCWr;
  logic        PCWrCond;
  logic        F3_result;
  logic [31:0] pc_target;
  logic [31:0] PC_Q;
  logic [31:0] IR_Q;
  logic [31:0] PC_old_D;
  logic        PColdWr;
  logic        fetch_done;
  logic        align_err;

  pc_fetch_unit_if #(.XLEN(32)) imem_bus ();

  pc_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK         (clk),
    .RSTn        (RSTn),
    .fetch_start (fetch_start),
    .PCWr        (PCWr),
    .PCWrCond    (PCWrCond),
    .F3_result   (F3_result),
    .pc_target   (pc_target),
    .imem        (imem_bus),
    .PC_Q        (PC_Q),
    .IR_Q        (IR_Q),
    .PC_old_D    (PC_old_D),
    .PColdWr     (PColdWr),
    .fetch_done  (fetch_done),
    .align_err   (align_err)
  );

  int total = 0;
  int bad   = 0;
  int nfetch = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: is a fetch outstanding, where is the PC, is a redirect
  // waiting for the outstanding fetch to finish, did a fetch just finish.
  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_just_done;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic        exp_req, exp_done, exp_align;
  logic [31:0] exp_addr, exp_pc;

  always @(negedge clk) begin
    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] nxt;
    if (!RSTn) begin
      m_pc = 32'h0; m_busy = 1'b0; m_just_done = 1'b0;
      m_pend = 1'b0; m_pend_tgt = 32'h0;
      sb_q.delete();
      exp_align = 1'b0;
    end else begin
      redirect  = PCWr || (PCWrCond && F3_result);
      tgt       = pc_target & 32'hFFFF_FFFC;
      exp_align = redirect && (pc_target % 32'd4 != 32'd0);
      if (m_busy) begin
        if (imem_bus.imem_ready) begin
          if (redirect)    nxt = tgt;
          else if (m_pend) nxt = m_pend_tgt;
          else             nxt = m_pc + 32'd4;
          sb_q.push_back('{ir: imem_bus.imem_rdata, pc_old: m_pc});
          m_pc = nxt; m_pend = 1'b0; m_busy = 1'b0; m_just_done = 1'b1;
        end else begin
          if (redirect) begin
            m_pend = 1'b1; m_pend_tgt = tgt;
          end
          m_just_done = 1'b0;
        end
      end else begin
        if (redirect) m_pc = tgt;
        m_busy      = fetch_start;
        m_just_done = 1'b0;
      end
    end
    exp_req  = m_busy;
    exp_addr = m_pc;
    exp_pc   = m_pc;
    exp_done = m_just_done;
  end

  // ---------------- monitor ----------------
  logic prev_pcoldwr = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (RSTn) begin
      chk("imem_req", 32'(imem_bus.imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_bus.imem_addr, exp_addr);
      chk("PC_Q", PC_Q, exp_pc);
      chk("fetch_done", 32'(fetch_done), 32'(exp_done));
      chk("PColdWr", 32'(PColdWr), 32'(exp_done));
      chk("align_err", 32'(align_err), 32'(exp_align));
      chk("PColdWr_consecutive", 32'(prev_pcoldwr & PColdWr), 32'h0);
      if (fetch_done) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_fetch", 32'(sb_q.size()), 32'h1);
        end else begin
          e = sb_q.pop_front();
          chk("IR_Q", IR_Q, e.ir);
          chk("PC_old_D", PC_old_D, e.pc_old);
          nfetch++;
        end
      end
    end
    prev_pcoldwr = PColdWr;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic fs, input logic pwr, input logic pwc, input logic f3,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    @(posedge clk);
    #1;
    fetch_start         = fs;
    PCWr                = pwr;
    PCWrCond            = pwc;
    F3_result           = f3;
    pc_target           = tgt;
    imem_bus.imem_ready = rdy;
    imem_bus.imem_rdata = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
  endtask

  initial begin
    logic [31:0] rtgt;
    RSTn = 1'b0; fetch_start = 1'b0; PCWr = 1'b0; PCWrCond = 1'b0; F3_result = 1'b0;
    pc_target = 32'h0; imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
    #1;
    chk("rst_PC_Q", PC_Q, 32'h0);
    chk("rst_IR_Q", IR_Q, 32'h0);
    chk("rst_PC_old_D", PC_old_D, 32'h0);
    chk("rst_outputs", {28'h0, imem_bus.imem_req, PColdWr, fetch_done, align_err}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    RSTn = 1'b1;

    // First fetch at PC 0 with memory ready immediately.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("t1_IR_Q", IR_Q, 32'h0010_0093);
    chk("t1_PC_old_D", PC_old_D, 32'h0);
    chk("t1_PColdWr", 32'(PColdWr), 32'h1);
    chk("t1_PC_Q", PC_Q, 32'h4);
    idle(2);

    // Three wait cycles on imem_ready.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    idle(2);

    // Branch not taken, then taken, then fetch from the branch target.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h0);
    idle(1);
    chk("t3_not_taken_PC", PC_Q, 32'h8);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("t3_taken_PC", PC_Q, 32'h40);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    chk("t3_fetch_addr", imem_bus.imem_addr, 32'h40);
    idle(2);

    // Jump arriving while a fetch at 0x10 waits.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t4_addr_stable", imem_bus.imem_addr, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("t4_PC_Q", PC_Q, 32'h80);
    chk("t4_PC_old_D", PC_old_D, 32'h10);
    idle(2);

    // PC wrap-around.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("t5_wrap_PC", PC_Q, 32'h0);
    idle(1);

    // Misaligned jump target.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h43, 1'b1, 32'h0);
    idle(1);
    chk("t6_align_PC", PC_Q, 32'h40);
    chk("t6_align_err_hi", 32'(align_err), 32'h1);
    idle(1);
    chk("t6_align_err_lo", 32'(align_err), 32'h0);

    // Reset in the middle of a waiting fetch.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t7_req_before_rst", 32'(imem_bus.imem_req), 32'h1);
    RSTn = 1'b0;
    #1;
    chk("t7_req_dropped", 32'(imem_bus.imem_req), 32'h0);
    chk("t7_PC_Q", PC_Q, 32'h0);
    chk("t7_IR_Q", IR_Q, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    @(posedge clk); #1;
    RSTn = 1'b1;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       rtgt = 32'hFFFF_FFFC;
        1:       rtgt = 32'h0000_0043;
        default: rtgt = $urandom;
      endcase
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
            rtgt, ($urandom_range(0, 9) < 6), $urandom);
    end
    idle(6);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("fetches_seen", 32'(nfetch > 20), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_fetch_unit
